qspi_ram_responder: RTL and testbench

Synthesizable QPI RAM responder, the memory end of the processor's QSPI RAM interface. It decodes quad-mode write (0x02) and fast-read (0x0B) transactions from the initiator and serves them from an internal byte array. It sits beside the core in FPGA builds and in loopback benches, on the same clock as the initiator.

---
 rtl/qspi_resp_pkg.sv | 18 +
 rtl/qspi_resp_mem.sv | 44 ++++
 rtl/qspi_ram_responder.sv | 185 ++++++++++++++++++
 tb/tb_qspi_ram_responder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qspi_resp_pkg.sv
// Shared types and constants for the QPI RAM responder.
package qspi_resp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    READ,
    WRITE,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam logic [7:0] CMD_READ     = 8'h0B;
  localparam int         ADDR_NIBBLES = 6;

endpackage

// File: rtl/qspi_resp_mem.sv
// Byte array for the QPI RAM responder: one QSPI write port and a combinational read port.
// Optional host backdoor port when QSPI_RESP_BACKDOOR_EN is defined.
module qspi_resp_mem #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
`ifdef QSPI_RESP_BACKDOOR_EN
  input  logic                 rst,
  input  logic                 bd_we,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  logic [7:0]           bd_wdata,
  output logic [7:0]           bd_rdata,
`endif
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata
);

  logic [7:0] mem_array [2**ADDR_BITS];

`ifdef QSPI_RESP_BACKDOOR_EN
  // Host write wins when both ports hit the same byte in one cycle.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem_array[bd_addr] <= bd_wdata;
    end
    if (we && !(bd_we && (bd_addr == addr))) begin
      mem_array[addr] <= wdata;
    end
  end

  assign bd_rdata = rst ? 8'h00 : mem_array[bd_addr];
`else
  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[addr] <= wdata;
    end
  end
`endif

  assign rdata = mem_array[addr];

endmodule

// File: rtl/qspi_ram_responder.sv
// QPI RAM responder: decodes quad write (0x02) and fast read (0x0B) and serves them from qspi_resp_mem.
// Defining QSPI_RESP_BACKDOOR_EN adds the bd_* host port to the memory.
module qspi_ram_responder
  import qspi_resp_pkg::*;
#(
  parameter int ADDR_BITS    = 12,
  parameter int DUMMY_CYCLES = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_cs_n,
  input  logic                 spi_sck,
  input  logic [3:0]           spi_data_in,
  output logic [3:0]           spi_data_out,
`ifdef QSPI_RESP_BACKDOOR_EN
  input  logic                 bd_we,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  logic [7:0]           bd_wdata,
  output logic [7:0]           bd_rdata,
`endif
  output logic [3:0]           spi_data_oe
);

  state_t                 state_reg, state_next;
  logic                   sck_q;
  logic [3:0]             cnt_reg, cnt_next;
  logic [7:0]             cmd_reg, cmd_next;
  logic [ADDR_BITS-1:0]   addr_reg, addr_next;
  logic                   nib_hi_reg, nib_hi_next;
  logic [3:0]             wr_hi_reg, wr_hi_next;
  logic [3:0]             data_out_reg, data_out_next;
  logic [3:0]             oe_reg, oe_next;
  logic                   rise, fall;
  logic                   mem_we;
  logic [7:0]             mem_wdata;
  logic [7:0]             mem_rdata;

  assign rise = spi_sck & ~sck_q;
  assign fall = ~spi_sck & sck_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sck_q        <= 1'b0;
      cnt_reg      <= '0;
      cmd_reg      <= '0;
      addr_reg     <= '0;
      nib_hi_reg   <= 1'b1;
      wr_hi_reg    <= '0;
      data_out_reg <= '0;
      oe_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      sck_q        <= spi_sck;
      cnt_reg      <= cnt_next;
      cmd_reg      <= cmd_next;
      addr_reg     <= addr_next;
      nib_hi_reg   <= nib_hi_next;
      wr_hi_reg    <= wr_hi_next;
      data_out_reg <= data_out_next;
      oe_reg       <= oe_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    cmd_next      = cmd_reg;
    addr_next     = addr_reg;
    nib_hi_next   = nib_hi_reg;
    wr_hi_next    = wr_hi_reg;
    data_out_next = data_out_reg;
    oe_next       = oe_reg;
    mem_we        = 1'b0;
    mem_wdata     = {wr_hi_reg, spi_data_in};

    if (spi_cs_n) begin
      state_next    = IDLE;
      cnt_next      = '0;
      oe_next       = '0;
      data_out_next = '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          // A rise coincident with CS assertion is still the first command nibble.
          state_next = CMD;
          cnt_next   = '0;
          if (rise) begin
            cmd_next = {cmd_reg[3:0], spi_data_in};
            cnt_next = 4'd1;
          end
        end
        CMD: begin
          if (rise) begin
            cmd_next = {cmd_reg[3:0], spi_data_in};
            if (cnt_reg == 4'd1) begin
              state_next = ADDR;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 4'd1;
            end
          end
        end
        ADDR: begin
          if (rise) begin
            // Upper address bits simply shift out of the narrower register.
            addr_next = ADDR_BITS'({addr_reg, spi_data_in});
            if (cnt_reg == 4'(ADDR_NIBBLES - 1)) begin
              cnt_next    = '0;
              nib_hi_next = 1'b1;
              if (cmd_reg == CMD_READ) begin
                state_next = DUMMY;
              end else if (cmd_reg == CMD_WRITE) begin
                state_next = WRITE;
              end else begin
                state_next = IGNORE;
              end
            end else begin
              cnt_next = cnt_reg + 4'd1;
            end
          end
        end
        DUMMY: begin
          if (rise) begin
            if (cnt_reg == 4'(DUMMY_CYCLES - 1)) begin
              state_next = READ;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 4'd1;
            end
          end
        end
        READ: begin
          if (fall) begin
            oe_next       = 4'hF;
            data_out_next = nib_hi_reg ? mem_rdata[7:4] : mem_rdata[3:0];
            nib_hi_next   = ~nib_hi_reg;
            if (!nib_hi_reg) begin
              addr_next = addr_reg + ADDR_BITS'(1);
            end
          end
        end
        WRITE: begin
          if (rise) begin
            if (nib_hi_reg) begin
              wr_hi_next  = spi_data_in;
              nib_hi_next = 1'b0;
            end else begin
              mem_we      = 1'b1;
              addr_next   = addr_reg + ADDR_BITS'(1);
              nib_hi_next = 1'b1;
            end
          end
        end
        IGNORE: begin
          state_next = IGNORE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  qspi_resp_mem #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk     (clk),
`ifdef QSPI_RESP_BACKDOOR_EN
    .rst     (rst),
    .bd_we   (bd_we),
    .bd_addr (bd_addr),
    .bd_wdata(bd_wdata),
    .bd_rdata(bd_rdata),
`endif
    .we      (mem_we),
    .addr    (addr_reg),
    .wdata   (mem_wdata),
    .rdata   (mem_rdata)
  );

  assign spi_data_out = data_out_reg;
  assign spi_data_oe  = oe_reg;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// Bench for qspi_ram_responder: table-driven write/read rows plus abort, unknown-command and reset sequences.
module tb_qspi_ram_responder;
  import qspi_resp_pkg::*;

  localparam int ADDR_BITS = 12;
  localparam int DUMMY     = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 spi_cs_n = 1'b1;
  logic                 spi_sck = 1'b0;
  logic [3:0]           spi_data_in = 4'h0;
  logic [3:0]           spi_data_out;
  logic [3:0]           spi_data_oe;
`ifdef QSPI_RESP_BACKDOOR_EN
  logic                 bd_we = 1'b0;
  logic [ADDR_BITS-1:0] bd_addr = '0;
  logic [7:0]           bd_wdata = 8'h00;
  logic [7:0]           bd_rdata;
`endif

  qspi_ram_responder #(
    .ADDR_BITS   (ADDR_BITS),
    .DUMMY_CYCLES(DUMMY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_data_in (spi_data_in),
    .spi_data_out(spi_data_out),
`ifdef QSPI_RESP_BACKDOOR_EN
    .bd_we       (bd_we),
    .bd_addr     (bd_addr),
    .bd_wdata    (bd_wdata),
    .bd_rdata    (bd_rdata),
`endif
    .spi_data_oe (spi_data_oe)
  );

  always #5 clk = ~clk;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [23:0] wr_addr;
    logic [7:0]  wd0;
    logic [7:0]  wd1;
    logic [23:0] rd_addr;
    logic [7:0]  ex0;
    logic [7:0]  ex1;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One sck cycle: sample outputs left by the previous fall, present a nibble on the rise.
  task automatic pulse(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
    @(negedge clk);
    q           = spi_data_out;
    oe          = spi_data_oe;
    spi_data_in = d;
    spi_sck     = 1'b1;
    @(negedge clk);
    spi_sck     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] q, oe;
    logic [7:0] v;
    v = b;
    pulse(v[7:4], q, oe);
    pulse(v[3:0], q, oe);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] q, oe;
    logic [23:0] v;
    v = a;
    for (int i = 5; i >= 0; i--) pulse(v[i*4 +: 4], q, oe);
  endtask

  task automatic cs_start;
    @(negedge clk);
    spi_cs_n = 1'b0;
  endtask

  task automatic cs_end(input string name);
    @(negedge clk);
    spi_cs_n = 1'b1;
    @(negedge clk);
    check({name, "_oe_release"}, 32'(spi_data_oe), 32'h0);
  endtask

  task automatic dummies(input string name);
    logic [3:0] q, oe;
    for (int i = 0; i < DUMMY; i++) begin
      pulse(4'h0, q, oe);
      if (i == DUMMY - 1) check({name, "_dummy_oe"}, 32'(oe), 32'h0);
    end
  endtask

  // Pop one expected nibble per sck cycle and compare data and enable.
  task automatic read_nibbles(input int n, input string name);
    logic [3:0] q, oe, e;
    for (int i = 0; i < n; i++) begin
      pulse(4'h0, q, oe);
      e = exp_q.pop_front();
      check($sformatf("%s_nib%0d", name, i), 32'(q), 32'(e));
      check($sformatf("%s_oe%0d", name, i), 32'(oe), 32'hF);
    end
  endtask

  task automatic qspi_write(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1);
    cs_start;
    send_byte(CMD_WRITE);
    send_addr(a);
    send_byte(b0);
    send_byte(b1);
    cs_end("wr");
    $display("write addr=%06h data=%02h %02h", a, b0, b1);
  endtask

  task automatic qspi_read(input logic [23:0] a, input int nbytes, input string name);
    cs_start;
    send_byte(CMD_READ);
    send_addr(a);
    dummies(name);
    read_nibbles(nbytes * 2, name);
    cs_end(name);
    $display("read  addr=%06h bytes=%0d (%s)", a, nbytes, name);
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic [7:0] v;
    v = b;
    exp_q.push_back(v[7:4]);
    exp_q.push_back(v[3:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] q, oe;

    vecs[0] = '{24'h000100, 8'hA5, 8'h3C, 24'h000100, 8'hA5, 8'h3C};
    vecs[1] = '{24'h000FFF, 8'h11, 8'h22, 24'h000FFF, 8'h11, 8'h22};
    vecs[2] = '{24'h000001, 8'h5B, 8'hC7, 24'h000000, 8'h22, 8'h5B};
    vecs[3] = '{24'hFFF200, 8'hDE, 8'hAD, 24'h000200, 8'hDE, 8'hAD};
    vecs[4] = '{24'h000300, 8'h01, 8'hF0, 24'h7FF300, 8'h01, 8'hF0};

    repeat (3) @(negedge clk);
    check("reset_oe", 32'(spi_data_oe), 32'h0);
    check("reset_dout", 32'(spi_data_out), 32'h0);
`ifdef QSPI_RESP_BACKDOOR_EN
    check("reset_bd_rdata", 32'(bd_rdata), 32'h0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", 32'(dut.state_reg), 32'(IDLE));

    for (int i = 0; i < 5; i++) begin
      qspi_write(vecs[i].wr_addr, vecs[i].wd0, vecs[i].wd1);
      push_byte(vecs[i].ex0);
      push_byte(vecs[i].ex1);
      qspi_read(vecs[i].rd_addr, 2, $sformatf("vec%0d", i));
    end

    // CS released after only the high nibble of 0x77: the earlier 0x5A must survive.
    qspi_write(24'h000020, 8'h5A, 8'h5A);
    cs_start;
    send_byte(CMD_WRITE);
    send_addr(24'h000020);
    pulse(4'h7, q, oe);
    @(negedge clk);
    spi_cs_n = 1'b1;
    @(negedge clk);
    check("abort_oe", 32'(spi_data_oe), 32'h0);
    check("abort_state", 32'(dut.state_reg), 32'(IDLE));
    $display("abort addr=000020 after high nibble 7");
    push_byte(8'h5A);
    push_byte(8'h5A);
    qspi_read(24'h000020, 2, "abort_rd");

    // Unknown command must neither drive nor write.
    cs_start;
    send_byte(8'h9F);
    send_addr(24'h000100);
    for (int i = 0; i < 4; i++) begin
      pulse(4'(i + 1), q, oe);
      check($sformatf("unk_oe%0d", i), 32'(oe), 32'h0);
    end
    cs_end("unk");
    $display("unknown cmd 9f addr=000100");
    push_byte(8'hA5);
    push_byte(8'h3C);
    qspi_read(24'h000100, 2, "unk_rd");

    // Reset in the middle of a read phase.
    cs_start;
    send_byte(CMD_READ);
    send_addr(24'h000300);
    dummies("rstmid");
    push_byte(8'h01);
    read_nibbles(2, "rstmid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_oe", 32'(spi_data_oe), 32'h0);
    check("rstmid_dout", 32'(spi_data_out), 32'h0);
    rst = 1'b0;
    spi_cs_n = 1'b1;
    @(negedge clk);
    $display("reset during read addr=000300");
    push_byte(8'h01);
    push_byte(8'hF0);
    qspi_read(24'h000300, 2, "rstmid_rd");

`ifdef QSPI_RESP_BACKDOOR_EN
    @(negedge clk);
    bd_we = 1'b1;
    bd_addr = 12'h040;
    bd_wdata = 8'hEE;
    @(negedge clk);
    bd_we = 1'b0;
    check("bd_rdata", 32'(bd_rdata), 32'hEE);
    $display("backdoor write addr=040 data=ee");
    push_byte(8'hEE);
    qspi_read(24'h000040, 1, "bd_rd");

    // QSPI low-nibble commit coincides with a backdoor write to the same byte.
    cs_start;
    send_byte(CMD_WRITE);
    send_addr(24'h000040);
    pulse(4'h1, q, oe);
    @(negedge clk);
    spi_data_in = 4'h2;
    spi_sck = 1'b1;
    bd_we = 1'b1;
    bd_wdata = 8'hCD;
    @(negedge clk);
    spi_sck = 1'b0;
    bd_we = 1'b0;
    cs_end("bdcoll");
    check("bdcoll_rdata", 32'(bd_rdata), 32'hCD);
    $display("collision addr=040 qspi=12 backdoor=cd");
    push_byte(8'hCD);
    qspi_read(24'h000040, 1, "bdcoll_rd");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
